mor1kx_icache_refill_wb: RTL

Wishbone B3 burst master that services instruction-cache line refills. It is the responder to the icache refill handshake: it samples the miss address when refill is requested and fetches one full line critical-word-first, using a wrapping burst. Each returned word is delivered on the icache write port (wradr/wrdat/we). It sits between mor1kx_icache and the instruction bus, and reports bus errors back to the cache and fetch logic.

---
 rtl/mor1kx_icache_refill_wb.sv | 101 ++++++++++
 1 files changed

// File: rtl/mor1kx_icache_refill_wb.sv
// Wishbone B3 burst master for instruction-cache line refills.
// Fetches one line critical-word-first with a wrapping burst and streams each acked word to the cache.
module mor1kx_icache_refill_wb #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            refill_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] cpu_adr_match_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            refill_busy_o,
    output logic                            imem_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i
);
    localparam int AW = OPTION_OPERAND_WIDTH;
    localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int CW = BW - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [AW-1:0]  r_adr;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_off_inc;
    logic           w_busy;
    logic           w_last;
    logic           w_ack;
    logic           w_err;

    assign w_busy    = (r_state == BURST);
    assign w_last    = &r_cnt;
    // An error on the bus wins over a simultaneous ack: the word is not delivered.
    assign w_err     = w_busy & wbm_err_i;
    assign w_ack     = w_busy & wbm_ack_i & ~wbm_err_i;
    assign w_off_inc = r_adr[BW-1:2] + CW'(1);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (refill_req_i) w_state_next = BURST;
            BURST:   if (w_err || (w_ack && w_last)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Word offset wraps inside the line so the burst starts at the critical word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_adr <= '0;
            r_cnt <= '0;
        end else if (r_state == IDLE && refill_req_i) begin
            r_adr <= cpu_adr_match_i & ~AW'(3);
            r_cnt <= '0;
        end else if (w_ack) begin
            r_adr <= {r_adr[AW-1:BW], w_off_inc, 2'b00};
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_comb begin
        wbm_cyc_o     = w_busy;
        wbm_stb_o     = w_busy;
        wbm_cti_o     = w_busy ? (w_last ? 3'b111 : 3'b010) : 3'b000;
        we_o          = w_ack;
        imem_err_o    = w_err;
        refill_busy_o = w_busy;
    end

    assign wbm_adr_o = r_adr;
    assign wradr_o   = r_adr;
    assign wrdat_o   = wbm_dat_i;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hf;
    assign wbm_bte_o = (BW == 4) ? 2'b01 : 2'b10;

endmodule
